// File: rtl/seq_div_pkg.sv
// Shared constants for the sequential restoring divider: state encoding and default width.
package seq_div_pkg;

    localparam int unsigned SEQ_DIV_N = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_RUN  = S_RUN,
        ST_DONE = S_DONE
    } state_e;

endpackage

// File: rtl/seq_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor,
// keep the difference when it does not borrow.
module seq_div_step
    import seq_div_pkg::*;
#(
    parameter int unsigned N = SEQ_DIV_N
) (
    input  logic [N:0]   pr_i,
    input  logic         msb_i,
    input  logic [N-1:0] divisor_i,
    output logic [N:0]   pr_o,
    output logic         qbit_o
);

    logic [N+1:0] s_c;
    logic [N:0]   d_c;

    // pr_i[N] is always zero in practice; carrying it keeps the compare exact for any input.
    assign s_c    = {pr_i, msb_i};
    assign qbit_o = (s_c >= (N+2)'(divisor_i));
    assign d_c    = s_c[N:0] - (N+1)'(divisor_i);
    assign pr_o   = qbit_o ? d_c : s_c[N:0];

endmodule

// File: rtl/seq_div.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock.
module seq_div
    import seq_div_pkg::*;
#(
    parameter int unsigned N = SEQ_DIV_N
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [2*N-1:0] a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] q,
    output logic [N-1:0]   r,
    output logic           busy,
    output logic           done,
    output logic           div_zero
);

    localparam int unsigned DW = 2 * N;
    localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;

    state_e        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [N-1:0]  b_q, b_d;
    logic [N:0]    pr_q, pr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] q_q, q_d;
    logic [N-1:0]  r_q, r_d;
    logic          dz_q, dz_d;
    logic          busy_q, done_q;

    logic [N:0]    pr_nxt_c;
    logic          qbit_c;

    seq_div_step #(.N(N)) u_step (
        .pr_i      (pr_q),
        .msb_i     (div_q[DW-1]),
        .divisor_i (b_q),
        .pr_o      (pr_nxt_c),
        .qbit_o    (qbit_c)
    );

    // Next-state logic; the exit edge of DONE may accept a new request so that a held
    // start yields one divide every 2N+1 cycles.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        b_d     = b_q;
        pr_d    = pr_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        dz_d    = dz_q;

        case (state_q)
            ST_RUN: begin
                div_d = {div_q[DW-2:0], qbit_c};
                pr_d  = pr_nxt_c;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                    q_d     = {div_q[DW-2:0], qbit_c};
                    r_d     = pr_nxt_c[N-1:0];
                    dz_d    = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                if (start) begin
                    if (b == '0) begin
                        state_d = ST_DONE;
                        q_d     = '1;
                        r_d     = '0;
                        dz_d    = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                        div_d   = a;
                        b_d     = b;
                        pr_d    = '0;
                        cnt_d   = CW'(DW - 1);
                    end
                end
            end
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            b_q     <= '0;
            pr_q    <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            b_q     <= b_d;
            pr_q    <= pr_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
            busy_q  <= (state_d == ST_RUN);
            done_q  <= (state_d == ST_DONE);
        end
    end

    assign q        = q_q;
    assign r        = r_q;
    assign div_zero = dz_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div (N=4): vector table, hand-written timing sequences,
// exhaustive and random sweeps against an arithmetic reference.
module tb_seq_div;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [3:0] b;
    logic [7:0] q;
    logic [3:0] r;
    logic       busy;
    logic       done;
    logic       div_zero;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [7:0] a;
        logic [3:0] b;
        logic [7:0] eq;
        logic [3:0] er;
        logic       ed;
    } vec_t;

    vec_t vecs[6];

    seq_div #(.N(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .q        (q),
        .r        (r),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void model(input int ai, input int bi, output int eq, output int er, output int ed);
        if (bi == 0) begin
            eq = 255; er = 0; ed = 1;
        end else begin
            eq = ai / bi; er = ai % bi; ed = 0;
        end
    endfunction

    // One complete divide from IDLE, scrambling the operand inputs after acceptance.
    task automatic apply(input logic [7:0] ai, input logic [3:0] bi, input logic [7:0] eq,
                         input logic [3:0] er, input logic ed, input string tag);
        int cyc;
        bit busy_ok;
        a = ai; b = bi; start = 1'b1;
        tick();
        start = 1'b0;
        a = 8'($urandom);
        b = 4'($urandom);
        cyc = 1;
        busy_ok = 1'b1;
        while (!done && cyc < 20) begin
            if (busy !== !ed) busy_ok = 1'b0;
            tick();
            cyc++;
        end
        if (busy !== 1'b0) busy_ok = 1'b0;
        check({tag, " latency"}, 32'(cyc), ed ? 32'd1 : 32'd9);
        check({tag, " busy"}, 32'(busy_ok), 32'd1);
        check({tag, " q"}, 32'(q), 32'(eq));
        check({tag, " r"}, 32'(r), 32'(er));
        check({tag, " div_zero"}, 32'(div_zero), 32'(ed));
        tick();
        check({tag, " done pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int eq, er, ed, n_done, last;
        logic [7:0] ra;
        logic [3:0] rb;

        vecs[0] = '{a: 8'd117, b: 4'd13, eq: 8'd9,   er: 4'd0, ed: 1'b0};
        vecs[1] = '{a: 8'd200, b: 4'd7,  eq: 8'd28,  er: 4'd4, ed: 1'b0};
        vecs[2] = '{a: 8'd255, b: 4'd1,  eq: 8'd255, er: 4'd0, ed: 1'b0};
        vecs[3] = '{a: 8'd5,   b: 4'd15, eq: 8'd0,   er: 4'd5, ed: 1'b0};
        vecs[4] = '{a: 8'd99,  b: 4'd0,  eq: 8'hFF,  er: 4'd0, ed: 1'b1};
        vecs[5] = '{a: 8'd117, b: 4'd13, eq: 8'd9,   er: 4'd0, ed: 1'b0};

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        repeat (2) tick();
        check("reset q", 32'(q), 0);
        check("reset r", 32'(r), 0);
        check("reset busy", 32'(busy), 0);
        check("reset done", 32'(done), 0);
        check("reset div_zero", 32'(div_zero), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++)
            apply(vecs[i].a, vecs[i].b, vecs[i].eq, vecs[i].er, vecs[i].ed, $sformatf("vec%0d", i));

        // Starts during RUN (k+3) and on the final iteration edge (k+8) are ignored.
        a = 8'd117; b = 4'd13; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        a = 8'd200; b = 4'd7; start = 1'b1;
        tick();
        start = 1'b0;
        check("ign busy k+3", 32'(busy), 1);
        repeat (4) tick();
        a = 8'd5; b = 4'd15; start = 1'b1;
        tick();
        start = 1'b0;
        check("ign done", 32'(done), 1);
        check("ign q", 32'(q), 9);
        check("ign r", 32'(r), 0);
        tick();
        check("ign no restart", 32'(busy), 0);
        check("ign done low", 32'(done), 0);

        // Asynchronous reset in the middle of a run.
        a = 8'd117; b = 4'd13; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        check("mid-rst q", 32'(q), 0);
        check("mid-rst r", 32'(r), 0);
        check("mid-rst busy", 32'(busy), 0);
        check("mid-rst done", 32'(done), 0);
        check("mid-rst div_zero", 32'(div_zero), 0);
        repeat (2) tick();
        check("mid-rst no done", 32'(done), 0);
        rst_n = 1'b1;
        apply(8'd117, 4'd13, 8'd9, 4'd0, 1'b0, "post-rst");

        // Start held high: back-to-back divides, operands zeroed while running.
        a = 8'd117; b = 4'd13; start = 1'b1;
        n_done = 0; last = 0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (done) begin
                check("b2b q", 32'(q), 9);
                check("b2b r", 32'(r), 0);
                check("b2b div_zero", 32'(div_zero), 0);
                if (n_done > 0) check("b2b spacing", 32'(c - last), 9);
                last = c;
                n_done++;
                a = 8'd117; b = 4'd13;
            end else begin
                a = '0; b = '0;
            end
        end
        check("b2b count", 32'(n_done), 4);
        start = 1'b0;
        repeat (12) tick();

        for (int ai = 0; ai < 256; ai++) begin
            for (int bi = 1; bi < 16; bi++) begin
                model(ai, bi, eq, er, ed);
                apply(8'(ai), 4'(bi), 8'(eq), 4'(er), 1'(ed), "exh");
            end
        end

        for (int i = 0; i < 300; i++) begin
            ra = 8'($urandom);
            rb = 4'($urandom_range(0, 15));
            model(int'(ra), int'(rb), eq, er, ed);
            apply(ra, rb, 8'(eq), 4'(er), 1'(ed), "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
